// File: rtl/twiddle_pkg.sv
// Shared types and elaboration-time helpers for the twiddle rotator.
// Holds the quadrant encoding, the default coefficient format and the
// ROM-init function that produces rounded cos/sin values.
package twiddle_pkg;

  localparam int unsigned COEF_WIDTH_DEF = 16;
  localparam int unsigned ONE_Q = 1 << (COEF_WIDTH_DEF - 2);

  typedef logic signed [COEF_WIDTH_DEF-1:0] coef_t;

  // Top two bits of the twiddle index select the quadrant.
  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  localparam real TWO_PI = 6.283185307179586;

  // Rounded 2^(coef_width-2) * cos/sin(2*pi*i/2^log2_n), evaluated at
  // elaboration. Rounds half away from zero so the table is odd-symmetric.
  function automatic int rom_coef(input int unsigned i,
                                  input int unsigned log2_n,
                                  input int unsigned coef_width,
                                  input bit          sin_sel);
    real one;
    real th;
    real v;
    one = real'(1 << (coef_width - 2));
    th  = TWO_PI * real'(i) / real'(1 << log2_n);
    v   = sin_sel ? one * $sin(th) : one * $cos(th);
    if (v >= 0.0)
      return int'($floor(v + 0.5));
    else
      return -int'($floor(-v + 0.5));
  endfunction

endpackage

// File: rtl/twiddle_rotator_if.sv
// Stream bundle for the twiddle rotator: input beat (sample, index,
// inverse flag, frame marker) and rotated output beat with valid/ready.
interface twiddle_rotator_if #(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned LOG2_N     = 6
);

  logic                         s_valid;
  logic                         s_ready;
  logic signed [DATA_WIDTH-1:0] s_real;
  logic signed [DATA_WIDTH-1:0] s_imag;
  logic [LOG2_N-1:0]            s_k;
  logic                         s_inv;
  logic                         s_last;

  logic                         m_valid;
  logic                         m_ready;
  logic signed [DATA_WIDTH-1:0] m_real;
  logic signed [DATA_WIDTH-1:0] m_imag;
  logic                         m_last;

  // Rotator side.
  modport slave (
    input  s_valid, s_real, s_imag, s_k, s_inv, s_last, m_ready,
    output s_ready, m_valid, m_real, m_imag, m_last
  );

  // Source/sink side.
  modport master (
    output s_valid, s_real, s_imag, s_k, s_inv, s_last, m_ready,
    input  s_ready, m_valid, m_real, m_imag, m_last
  );

endinterface

// File: rtl/twiddle_rom.sv
// First-octant coefficient ROM: C[i], S[i] for i = 0..N/8, filled at
// elaboration, read through an enabled output register.
module twiddle_rom
  import twiddle_pkg::*;
#(
  parameter int unsigned LOG2_N     = 6,
  parameter int unsigned COEF_WIDTH = COEF_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic [LOG2_N-3:0]            addr,
  output logic signed [COEF_WIDTH-1:0] c,
  output logic signed [COEF_WIDTH-1:0] s
);

  localparam int unsigned DEPTH = ((1 << LOG2_N) / 8) + 1;

  logic signed [COEF_WIDTH-1:0] rom_c [DEPTH];
  logic signed [COEF_WIDTH-1:0] rom_s [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam int CI = rom_coef(i, LOG2_N, COEF_WIDTH, 1'b0);
    localparam int SI = rom_coef(i, LOG2_N, COEF_WIDTH, 1'b1);
    assign rom_c[i] = COEF_WIDTH'(CI);
    assign rom_s[i] = COEF_WIDTH'(SI);
  end

  // Registered read, frozen while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (en) begin
      c <= rom_c[addr];
      s <= rom_s[addr];
    end
  end

endmodule

// File: rtl/twiddle_rotator.sv
// Runtime-indexed twiddle multiplier: out = in * W_N^k (or conj for inverse).
// Three lock-step stages (fold+ROM, products, round+narrow) with a global
// stall enable driven from the output handshake.
// Build option: define TWIDDLE_SAT_EN to saturate out-of-range results;
// otherwise results wrap to DATA_WIDTH bits.
module twiddle_rotator
  import twiddle_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned COEF_WIDTH = COEF_WIDTH_DEF,
  parameter int unsigned LOG2_N     = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  twiddle_rotator_if.slave bus
);

  localparam int unsigned AW = LOG2_N - 2;
  localparam int unsigned PW = DATA_WIDTH + COEF_WIDTH;
  localparam int unsigned FW = PW + 1;
  localparam int unsigned SH = COEF_WIDTH - 2;
  localparam int unsigned RW = FW - SH;

  localparam logic [AW:0]          QTR = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]          OCT = QTR >> 1;
  localparam logic signed [FW-1:0] RND = FW'(1) << (SH - 1);

  typedef logic signed [COEF_WIDTH-1:0] cw_t;
  typedef logic signed [DATA_WIDTH-1:0] dw_t;
  typedef logic signed [PW-1:0]         pw_t;

  logic en;

  // Fold stage (combinational into P1)
  logic [AW:0]   m_ext;
  logic [AW:0]   m_mirror;
  logic          swap_in;
  logic [AW-1:0] rom_addr;

  // P1
  logic  v1;
  dw_t   re1;
  dw_t   im1;
  logic  inv1;
  logic  last1;
  quad_e q1;
  logic  swap1;
  cw_t   c_rom;
  cw_t   s_rom;

  // Quadrant mapping (combinational into P2)
  cw_t cp;
  cw_t sp;
  cw_t c_q;
  cw_t s_q;

  // P2
  logic v2;
  logic last2;
  pw_t  pr_rc;
  pw_t  pr_is;
  pw_t  pr_ic;
  pw_t  pr_rs;

  // P3 combinational
  logic signed [FW-1:0] re_full;
  logic signed [FW-1:0] im_full;
  logic signed [RW-1:0] re_rnd;
  logic signed [RW-1:0] im_rnd;
  dw_t                  re_out;
  dw_t                  im_out;

  assign en          = !bus.m_valid || bus.m_ready;
  assign bus.s_ready = en;

  // Narrow a rounded result to the output width.
  function automatic dw_t narrow(input logic signed [RW-1:0] v);
`ifdef TWIDDLE_SAT_EN
    logic signed [RW-1:0] maxv;
    logic signed [RW-1:0] minv;
    maxv = {{(RW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    minv = {{(RW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
    if (v > maxv)
      return DATA_WIDTH'(maxv);
    else if (v < minv)
      return DATA_WIDTH'(minv);
    else
      return DATA_WIDTH'(v);
`else
    return DATA_WIDTH'(v);
`endif
  endfunction

  // Fold k mod N/4 into the first octant; past N/8 read the mirrored entry
  // and swap cos/sin.
  always_comb begin
    m_ext    = {1'b0, bus.s_k[AW-1:0]};
    m_mirror = QTR - m_ext;
    swap_in  = (m_ext > OCT);
    rom_addr = swap_in ? m_mirror[AW-1:0] : m_ext[AW-1:0];
  end

  twiddle_rom #(
    .LOG2_N     (LOG2_N),
    .COEF_WIDTH (COEF_WIDTH)
  ) u_rom (
    .clk  (clk),
    .en   (en),
    .addr (rom_addr),
    .c    (c_rom),
    .s    (s_rom)
  );

  // P1 payload: sample and side-band alongside the ROM read.
  always_ff @(posedge clk) begin
    if (en) begin
      re1   <= bus.s_real;
      im1   <= bus.s_imag;
      inv1  <= bus.s_inv;
      last1 <= bus.s_last;
      q1    <= quad_e'(bus.s_k[LOG2_N-1 -: 2]);
      swap1 <= swap_in;
    end
  end

  // Undo the octant fold, rotate into the quadrant, conjugate if inverse.
  always_comb begin
    cp  = swap1 ? s_rom : c_rom;
    sp  = swap1 ? c_rom : s_rom;
    c_q = cp;
    s_q = sp;
    case (q1)
      QUAD_0: begin c_q = cp;  s_q = sp;  end
      QUAD_1: begin c_q = -sp; s_q = cp;  end
      QUAD_2: begin c_q = -cp; s_q = -sp; end
      QUAD_3: begin c_q = sp;  s_q = -cp; end
      default: begin c_q = cp; s_q = sp; end
    endcase
    if (inv1)
      s_q = -s_q;
  end

  // P2 payload: four full-width partial products.
  always_ff @(posedge clk) begin
    if (en) begin
      pr_rc <= re1 * c_q;
      pr_is <= im1 * s_q;
      pr_ic <= im1 * c_q;
      pr_rs <= re1 * s_q;
      last2 <= last1;
    end
  end

  // Combine, round half up, then narrow.
  always_comb begin
    re_full = FW'(pr_rc) + FW'(pr_is);
    im_full = FW'(pr_ic) - FW'(pr_rs);
    re_rnd  = RW'((re_full + RND) >>> SH);
    im_rnd  = RW'((im_full + RND) >>> SH);
    re_out  = narrow(re_rnd);
    im_out  = narrow(im_rnd);
  end

  // Stage valids and output register; outputs only load on a real beat so
  // they stay put across bubbles and stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_real  <= '0;
      bus.m_imag  <= '0;
      bus.m_last  <= 1'b0;
    end else if (en) begin
      v1          <= bus.s_valid;
      v2          <= v1;
      bus.m_valid <= v2;
      if (v2) begin
        bus.m_real <= re_out;
        bus.m_imag <= im_out;
        bus.m_last <= last2;
      end
    end
  end

endmodule
